// File: rtl/playseq_gravador_if.sv
// playseq_gravador_if -- signal bundle between the game datapath and the
// sequence recorder.
//
// Signals (direction seen from the recorder, i.e. the slave modport):
//   iniciar      in   start a new recording (level, honoured in INICIAL)
//   encerrar     in   end recording early (level, honoured in ESPERA)
//   botoes       in   [3:0] synchronized player buttons
//   rd_endereco  in   [3:0] read address
//   rd_dado      out  [3:0] registered read data (1-cycle latency)
//   comprimento  out  [3:0] index of the last stored entry
//   valida       out  a complete recorded sequence is stored
//   gravando     out  recording in progress (ESPERA or SOLTA)
//   pronto       out  one-cycle pulse when a recording completes
//   erro_jogada  out  one-cycle pulse on a non-one-hot press
//   timeout      out  one-cycle pulse when the idle limit expires
//   db_estado    out  [3:0] state code for debug
interface playseq_gravador_if;
    logic       iniciar;
    logic       encerrar;
    logic [3:0] botoes;
    logic [3:0] rd_endereco;
    logic [3:0] rd_dado;
    logic [3:0] comprimento;
    logic       valida;
    logic       gravando;
    logic       pronto;
    logic       erro_jogada;
    logic       timeout;
    logic [3:0] db_estado;

    // Game datapath / test driver side.
    modport master (
        output iniciar, encerrar, botoes, rd_endereco,
        input  rd_dado, comprimento, valida, gravando, pronto,
               erro_jogada, timeout, db_estado
    );

    // Recorder side.
    modport slave (
        input  iniciar, encerrar, botoes, rd_endereco,
        output rd_dado, comprimento, valida, gravando, pronto,
               erro_jogada, timeout, db_estado
    );
endinterface

// File: rtl/playseq_gravador.sv
// playseq_gravador -- records a sequence of up to 16 button presses into a
// 16x4 array and exposes it through a registered read port.
//
// Ports:
//   clock  in   single clock, rising edge
//   clr    in   synchronous active-low reset
//   bus    playseq_gravador_if.slave (see the interface file for signals)
//
// Parameters:
//   TIMEOUT_M  idle cycles in ESPERA before the recording is closed
//   TIMEOUT_N  width of the idle counter (2**TIMEOUT_N >= TIMEOUT_M)
//
// Optional feature: define PLAYSEQ_GRAVADOR_TIMEOUT_EN to build the idle
// counter. Without it, timeout is tied low and ESPERA waits indefinitely.
//
// The storage array is deliberately not reset; valida=0 marks it unusable.
module playseq_gravador #(
    parameter int TIMEOUT_M = 5000,
    parameter int TIMEOUT_N = 13
) (
    input  logic                clock,
    input  logic                clr,
    playseq_gravador_if.slave   bus
);

    if ((2 ** TIMEOUT_N) < TIMEOUT_M) begin : g_bad_timeout_cfg
        $error("playseq_gravador: TIMEOUT_N too narrow for TIMEOUT_M");
    end

    typedef enum logic [1:0] {
        INICIAL = 2'd0,
        ESPERA  = 2'd1,
        SOLTA   = 2'd2,
        FIM     = 2'd3
    } estado_t;

    estado_t    estado;
    logic [3:0] ptr;
    logic       full;
    logic       prev;
    logic       valida;
    logic [3:0] comprimento;
    logic       pronto;
    logic       erro_jogada;
    logic [3:0] rd_dado;
    logic [3:0] mem [16];

    logic       edge_press;
    logic       mem_we;
    logic       tmo_hit;

    function automatic logic is_onehot(input logic [3:0] b);
        return (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
    endfunction

    // A press is the rising edge of "any button"; prev tracks it in every
    // state so a button already held when ESPERA is entered is not an edge.
    assign edge_press = (|bus.botoes) & ~prev;
    assign mem_we     = clr && (estado == ESPERA) && edge_press
                        && is_onehot(bus.botoes);

`ifdef PLAYSEQ_GRAVADOR_TIMEOUT_EN
    localparam logic [TIMEOUT_N-1:0] TMO_LAST = TIMEOUT_N'(TIMEOUT_M - 1);

    logic [TIMEOUT_N-1:0] tmo_cnt;
    logic                 timeout_q;

    // Held at zero outside ESPERA, so every entry into ESPERA starts from 0.
    always_ff @(posedge clock) begin
        if (!clr) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (estado == ESPERA) && !edge_press && tmo_hit;
            if (estado != ESPERA || edge_press)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit     = (tmo_cnt == TMO_LAST);
    assign bus.timeout = timeout_q;
`else
    assign tmo_hit     = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // Control FSM: pronto/valida/comprimento are loaded on the transition
    // into FIM, so pronto is high exactly while db_estado reads FIM.
    always_ff @(posedge clock) begin
        if (!clr) begin
            estado      <= INICIAL;
            ptr         <= 4'd0;
            full        <= 1'b0;
            prev        <= 1'b0;
            valida      <= 1'b0;
            comprimento <= 4'd0;
            pronto      <= 1'b0;
            erro_jogada <= 1'b0;
        end else begin
            prev        <= |bus.botoes;
            pronto      <= 1'b0;
            erro_jogada <= 1'b0;
            case (estado)
                INICIAL: begin
                    if (bus.iniciar) begin
                        ptr    <= 4'd0;
                        full   <= 1'b0;
                        valida <= 1'b0;
                        estado <= ESPERA;
                    end
                end
                ESPERA: begin
                    // A press wins over encerrar/timeout in the same cycle.
                    if (edge_press) begin
                        if (is_onehot(bus.botoes)) begin
                            if (ptr == 4'd15)
                                full <= 1'b1;
                            else
                                ptr <= ptr + 4'd1;
                        end else begin
                            erro_jogada <= 1'b1;
                        end
                        estado <= SOLTA;
                    end else if (bus.encerrar || tmo_hit) begin
                        // full is never set while in ESPERA, so ptr is the
                        // entry count here.
                        if (ptr != 4'd0) begin
                            estado      <= FIM;
                            pronto      <= 1'b1;
                            valida      <= 1'b1;
                            comprimento <= ptr - 4'd1;
                        end else begin
                            estado <= INICIAL;
                            valida <= 1'b0;
                        end
                    end
                end
                SOLTA: begin
                    if (bus.botoes == 4'd0) begin
                        if (full) begin
                            estado      <= FIM;
                            pronto      <= 1'b1;
                            valida      <= 1'b1;
                            comprimento <= 4'd15;
                        end else begin
                            estado <= ESPERA;
                        end
                    end
                end
                FIM: begin
                    estado <= INICIAL;
                end
                default: begin
                    estado <= INICIAL;
                end
            endcase
        end
    end

    // Storage write: no reset on the array contents.
    always_ff @(posedge clock) begin
        if (mem_we)
            mem[ptr] <= bus.botoes;
    end

    // Registered read; a same-cycle write to the same address returns the
    // old word because both use non-blocking updates.
    always_ff @(posedge clock) begin
        if (!clr)
            rd_dado <= 4'd0;
        else
            rd_dado <= mem[bus.rd_endereco];
    end

    assign bus.rd_dado     = rd_dado;
    assign bus.comprimento = comprimento;
    assign bus.valida      = valida;
    assign bus.gravando    = (estado == ESPERA) || (estado == SOLTA);
    assign bus.pronto      = pronto;
    assign bus.erro_jogada = erro_jogada;
    assign bus.db_estado   = {2'b00, estado};

endmodule
